key_fetch_bridge: RTL and testbench
===================================

Name: key_fetch_bridge

Overview:
- Serves encrypt-stage key-address requests (e_axi_raddr/e_axi_rvalid, which have no ready) over a full AXI4 read master.
- Returns the key line on the encrypt stage's response inputs (e_axi_rd_rvalid/e_axi_rd_data/e_axi_rd_last).
- Buffers requests, limits outstanding reads, flags protocol and response errors.
- Sits between the encrypt stage and the key-memory AXI interconnect.

Parameters:
C_AXI_ID_WIDTH, 4, AXI ID width
C_AXI_ADDR_WIDTH, 32, request/AXI address width
C_AXI_DATA_WIDTH, 512, AXI read data width (one key line per beat)
C_ARID, 0, constant ARID driven on every read
REQ_DEPTH, 4, request FIFO depth (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum issued-but-unreturned reads (1..15)
TIMEOUT_CYCLES, 1024, cycles with reads outstanding and no R beat before timeout flag

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
req_addr  in  C_AXI_ADDR_WIDTH  key line address from encrypt stage
req_valid  in  1  single-cycle request strobe; no backpressure
rsp_valid  out  1  key data valid (to e_axi_rd_rvalid)
rsp_data  out  C_AXI_DATA_WIDTH  key line (to e_axi_rd_data)
rsp_last  out  1  last beat (to e_axi_rd_last)
m_axi_arid  out  C_AXI_ID_WIDTH  = C_ARID
m_axi_araddr  out  C_AXI_ADDR_WIDTH  read address
m_axi_arlen  out  8  constant 0
m_axi_arsize  out  3  constant log2(C_AXI_DATA_WIDTH/8) (6 for 512)
m_axi_arburst  out  2  constant 2'b01
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  C_AXI_ID_WIDTH  R id
m_axi_rdata  in  C_AXI_DATA_WIDTH  R data
m_axi_rresp  in  2  R response
m_axi_rlast  in  1  R last
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
status_clr  in  1  clears sticky flags and drop count
err_drop  out  1  sticky: request lost on full FIFO
err_resp  out  1  sticky: RRESP!=0 or RID!=C_ARID
err_timeout  out  1  sticky: timeout expired
drop_cnt  out  8  saturating count of dropped requests
outstanding  out  4  current outstanding read count

Behaviour:
- Reset (async assert, sync release): FIFO empty, outstanding=0, m_axi_arvalid=0, m_axi_araddr=0, rsp_valid=0, rsp_data=0, rsp_last=0, all err flags=0, drop_cnt=0, timeout counter=0, AR FSM IDLE. m_axi_rready=0 in reset, 1 otherwise.
- Request capture: req_valid && !full -> push req_addr with low log2(C_AXI_DATA_WIDTH/8) bits forced to 0. req_valid && full -> drop, err_drop=1, drop_cnt+1 saturating at 255. Push and pop in same cycle on full FIFO: pop frees space first, push accepted.
- AR FSM, IDLE: FIFO non-empty and outstanding<MAX_OUTSTANDING -> pop, load araddr, arvalid=1 next cycle, go ADDR. Earliest arvalid is 2 cycles after req_valid.
- AR FSM, ADDR: hold arvalid and araddr stable until arvalid&&arready. On handshake: arvalid=0, outstanding+1, go IDLE. No back-to-back AR; one idle cycle minimum between issues.
- R path: rready=1 constant. On rvalid: registered 1-cycle forward: rsp_valid=1, rsp_data=rdata, rsp_last=rlast.
- RRESP!=0 or RID!=C_ARID: err_resp=1, rsp_data forced to 0, rsp_valid still asserted so downstream never hangs.
- rvalid&&rlast: outstanding-1. Same cycle as AR handshake: outstanding unchanged. R beat with outstanding=0 is unexpected: err_resp=1, forwarded as above, counter stays 0 (no underflow).
- Timeout: counter increments each cycle with outstanding>0 and !rvalid; clears on rvalid or outstanding=0. Reaching TIMEOUT_CYCLES sets err_timeout; counter holds; no recovery action.
- status_clr: clears err_drop, err_resp, err_timeout, drop_cnt next cycle. A same-cycle set event wins over clear.
- Reset mid-transaction: all state dropped immediately; late R beats after release are handled as unexpected (err_resp).

Test Plan:
- Single request req_addr=0x0000_1047 -> araddr=0x0000_1040, arvalid at cycle+2; arready same cycle; R beat rdata=pattern A, rresp=0 -> rsp_valid 1 cycle later with data A, rsp_last=1, outstanding back to 0.
- Hold arready=0 for 10 cycles -> arvalid and araddr stable throughout; handshake on cycle 11; one AR only.
- Five req_valid pulses back-to-back with arready=0 (REQ_DEPTH=4, first popped) -> 0 drops; sixth pulse -> err_drop=1, drop_cnt=1; after status_clr -> both 0.
- MAX_OUTSTANDING=2, arready=1, no R -> exactly 2 ARs issued, third waits; one R returns -> third AR issued; outstanding never >2.
- rresp=2'b10 on a beat -> rsp_valid=1, rsp_data=0, err_resp=1; R beat with outstanding=0 -> err_resp=1, outstanding stays 0.
- TIMEOUT_CYCLES=16, one AR issued, no R -> err_timeout=1 after 16 cycles; areset pulse mid-wait -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/key_fetch_bridge.sv
// Key-fetch bridge: buffers encrypt-stage key-line requests and issues them as
// single-beat AXI4 reads, forwarding returned lines and flagging errors.
module key_fetch_bridge #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 512,
    parameter int C_ARID           = 0,
    parameter int REQ_DEPTH        = 4,
    parameter int MAX_OUTSTANDING  = 2,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [C_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic                        req_valid,
    output logic                        rsp_valid,
    output logic [C_AXI_DATA_WIDTH-1:0] rsp_data,
    output logic                        rsp_last,
    output logic [C_AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [C_AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic                        status_clr,
    output logic                        err_drop,
    output logic                        err_resp,
    output logic                        err_timeout,
    output logic [7:0]                  drop_cnt,
    output logic [3:0]                  outstanding
);

    localparam int SIZE_LOG2 = $clog2(C_AXI_DATA_WIDTH / 8);
    localparam int PTR_W     = $clog2(REQ_DEPTH);
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W:0]            FIFO_FULL_C = (PTR_W + 1)'(REQ_DEPTH);
    localparam logic [3:0]                MAX_OUT_C   = 4'(MAX_OUTSTANDING);
    localparam logic [C_AXI_ID_WIDTH-1:0] ARID_C      = C_AXI_ID_WIDTH'(C_ARID);
    localparam logic [TMO_W-1:0]          TMO_MAX_C   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]          TMO_LAST_C  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_ADDR = 1'b1
    } ar_state_t;

    ar_state_t                   state_r, state_next_s;
    logic [C_AXI_ADDR_WIDTH-1:0] fifo_mem_r [REQ_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]              count_r;
    logic                        full_s, empty_s, push_s, pop_s, drop_s;
    logic                        ar_hs_s, r_fire_s, r_dec_s, resp_bad_s, unexpected_s;
    logic                        tmo_inc_s, tmo_set_s;
    logic [TMO_W-1:0]            tmo_cnt_r;
    logic [C_AXI_ADDR_WIDTH-1:0] araddr_r;
    logic                        arvalid_r, rready_r;
    logic                        rsp_valid_r, rsp_last_r;
    logic [C_AXI_DATA_WIDTH-1:0] rsp_data_r;
    logic                        err_drop_r, err_resp_r, err_timeout_r;
    logic [7:0]                  drop_cnt_r;
    logic [3:0]                  outstanding_r;

    assign full_s       = (count_r == FIFO_FULL_C);
    assign empty_s      = (count_r == '0);
    assign push_s       = req_valid && (!full_s || pop_s);
    assign drop_s       = req_valid && !push_s;
    assign ar_hs_s      = arvalid_r && m_axi_arready;
    assign r_fire_s     = m_axi_rvalid && rready_r;
    assign r_dec_s      = r_fire_s && m_axi_rlast && (outstanding_r != 4'd0);
    assign resp_bad_s   = r_fire_s && ((m_axi_rresp != 2'b00) || (m_axi_rid != ARID_C));
    assign unexpected_s = r_fire_s && (outstanding_r == 4'd0);
    assign tmo_inc_s    = (outstanding_r != 4'd0) && !m_axi_rvalid;
    assign tmo_set_s    = tmo_inc_s && (tmo_cnt_r >= TMO_LAST_C);

    // AR FSM next-state: pop a request only when the outstanding budget allows.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            AR_IDLE: begin
                if (!empty_s && (outstanding_r < MAX_OUT_C)) begin
                    pop_s        = 1'b1;
                    state_next_s = AR_ADDR;
                end else begin
                    state_next_s = AR_IDLE;
                end
            end
            AR_ADDR: begin
                if (ar_hs_s) begin
                    state_next_s = AR_IDLE;
                end else begin
                    state_next_s = AR_ADDR;
                end
            end
            default: state_next_s = AR_IDLE;
        endcase
    end

    // AR FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= AR_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {req_addr[C_AXI_ADDR_WIDTH-1:SIZE_LOG2], {SIZE_LOG2{1'b0}}};
        end
    end

    // Request FIFO pointers and occupancy.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // AR channel: address is captured on pop and held until the handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arvalid_r <= 1'b0;
            araddr_r  <= '0;
        end else if (pop_s) begin
            arvalid_r <= 1'b1;
            araddr_r  <= fifo_mem_r[rd_ptr_r];
        end else if (ar_hs_s) begin
            arvalid_r <= 1'b0;
        end else begin
            arvalid_r <= arvalid_r;
        end
    end

    // Outstanding read tracking; a beat with nothing outstanding never underflows.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            outstanding_r <= 4'd0;
        end else begin
            case ({ar_hs_s, r_dec_s})
                2'b10:   outstanding_r <= outstanding_r + 4'd1;
                2'b01:   outstanding_r <= outstanding_r - 4'd1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // R forwarding; errored beats still strobe valid so the consumer never stalls.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_last_r  <= 1'b0;
            rsp_data_r  <= '0;
        end else begin
            rready_r <= 1'b1;
            if (r_fire_s) begin
                rsp_valid_r <= 1'b1;
                rsp_last_r  <= m_axi_rlast;
                rsp_data_r  <= resp_bad_s ? '0 : m_axi_rdata;
            end else begin
                rsp_valid_r <= 1'b0;
                rsp_last_r  <= 1'b0;
            end
        end
    end

    // Timeout counter saturates at the limit so the flag re-asserts while stalled.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tmo_cnt_r <= '0;
        end else if (!tmo_inc_s) begin
            tmo_cnt_r <= '0;
        end else if (tmo_cnt_r != TMO_MAX_C) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Sticky status; a set event in the same cycle as status_clr takes priority.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_drop_r    <= 1'b0;
            err_resp_r    <= 1'b0;
            err_timeout_r <= 1'b0;
            drop_cnt_r    <= 8'd0;
        end else begin
            err_drop_r    <= drop_s ? 1'b1 : (status_clr ? 1'b0 : err_drop_r);
            err_resp_r    <= (resp_bad_s || unexpected_s) ? 1'b1 : (status_clr ? 1'b0 : err_resp_r);
            err_timeout_r <= tmo_set_s ? 1'b1 : (status_clr ? 1'b0 : err_timeout_r);
            if (drop_s) begin
                drop_cnt_r <= (drop_cnt_r == 8'd255) ? drop_cnt_r : drop_cnt_r + 8'd1;
            end else if (status_clr) begin
                drop_cnt_r <= 8'd0;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign m_axi_arid    = ARID_C;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'(SIZE_LOG2);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_last      = rsp_last_r;
    assign err_drop      = err_drop_r;
    assign err_resp      = err_resp_r;
    assign err_timeout   = err_timeout_r;
    assign drop_cnt      = drop_cnt_r;
    assign outstanding   = outstanding_r;

endmodule

// File: tb/tb_key_fetch_bridge.sv
// Directed bench for key_fetch_bridge: linear stimulus with hand-computed
// expectations checked by immediate assertions.
module tb_key_fetch_bridge;

    logic         aclk;
    logic         areset;
    logic [31:0]  req_addr;
    logic         req_valid;
    logic         rsp_valid;
    logic [511:0] rsp_data;
    logic         rsp_last;
    logic [3:0]   m_axi_arid;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [3:0]   m_axi_rid;
    logic [511:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic         status_clr;
    logic         err_drop;
    logic         err_resp;
    logic         err_timeout;
    logic [7:0]   drop_cnt;
    logic [3:0]   outstanding;

    int n_checks = 0;
    int n_fail   = 0;
    int ar_count;
    int waited;

    logic [511:0] pat_a;
    logic [511:0] pat_b;

    key_fetch_bridge #(
        .C_AXI_ID_WIDTH  (4),
        .C_AXI_ADDR_WIDTH(32),
        .C_AXI_DATA_WIDTH(512),
        .C_ARID          (0),
        .REQ_DEPTH       (4),
        .MAX_OUTSTANDING (2),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .req_addr     (req_addr),
        .req_valid    (req_valid),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .m_axi_arid   (m_axi_arid),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid    (m_axi_rid),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .status_clr   (status_clr),
        .err_drop     (err_drop),
        .err_resp     (err_resp),
        .err_timeout  (err_timeout),
        .drop_cnt     (drop_cnt),
        .outstanding  (outstanding)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pat_a = {16{32'hA5C3_1F07}};
        pat_b = {16{32'h5A3C_E0F8}};
        areset = 1'b1; req_addr = 32'h0; req_valid = 1'b0; m_axi_arready = 1'b0;
        m_axi_rid = 4'h0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0; status_clr = 1'b0;
        repeat (3) tick();

        // Reset values and constant AR fields
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_araddr", m_axi_araddr, 32'h0);
        check("rst_rready", m_axi_rready, 1'b0);
        check("rst_rsp", {rsp_valid, rsp_last, rsp_data}, '0);
        check("rst_flags", {err_drop, err_resp, err_timeout, drop_cnt, outstanding}, '0);
        check("const_ar", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst}, {4'h0, 8'h00, 3'd6, 2'b01});

        areset = 1'b0;
        tick();
        check("rready_after_rst", m_axi_rready, 1'b1);

        // Single request: alignment, two-cycle AR latency, R forwarding
        m_axi_arready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0000_1047;
        tick();
        req_valid = 1'b0;
        check("t1_arvalid_c1", m_axi_arvalid, 1'b0);
        tick();
        check("t1_arvalid_c2", m_axi_arvalid, 1'b1);
        check("t1_araddr", m_axi_araddr, 32'h0000_1040);
        tick();
        check("t1_ar_done", m_axi_arvalid, 1'b0);
        check("t1_outst_1", outstanding, 4'd1);
        m_axi_rvalid = 1'b1; m_axi_rdata = pat_a; m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_rsp_data", rsp_data, pat_a);
        check("t1_rsp_last", rsp_last, 1'b1);
        check("t1_outst_0", outstanding, 4'd0);
        check("t1_err_resp", err_resp, 1'b0);
        tick();
        check("t1_rsp_pulse", rsp_valid, 1'b0);

        // AR held under backpressure for 10 cycles
        m_axi_arready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h2000_0085;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t2_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h2000_0080});
            tick();
        end
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        check("t2_ar_done", m_axi_arvalid, 1'b0);
        check("t2_outst", outstanding, 4'd1);
        tick();
        tick();
        check("t2_one_ar", m_axi_arvalid, 1'b0);
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        check("t2_outst_0", outstanding, 4'd0);

        // Fill FIFO with AR stalled, then overflow by one
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = 32'(i + 1) << 8;
            tick();
        end
        check("t3_no_drop", {err_drop, drop_cnt}, {1'b0, 8'd0});
        req_addr = 32'h0000_0600;
        tick();
        req_valid = 1'b0;
        check("t3_err_drop", err_drop, 1'b1);
        check("t3_drop_cnt", drop_cnt, 8'd1);
        check("t3_ar_head", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h0000_0100});
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        check("t3_clr", {err_drop, drop_cnt}, {1'b0, 8'd0});

        // Outstanding limit: only two ARs issue without R responses
        m_axi_arready = 1'b1;
        ar_count = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_axi_arvalid && m_axi_arready) ar_count++;
            check("t4_le_max", outstanding <= 4'd2, 1'b1);
            tick();
        end
        check("t4_ar_count", ar_count, 2);
        check("t4_outst_2", outstanding, 4'd2);
        check("t4_third_waits", m_axi_arvalid, 1'b0);
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        check("t4_outst_1", outstanding, 4'd1);
        waited = 0;
        while (!m_axi_arvalid && waited < 8) begin
            tick();
            waited++;
        end
        check("t4_third_ar", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h0000_0300});
        tick();
        m_axi_arready = 1'b0;
        check("t4_outst_2b", outstanding, 4'd2);

        // Error response: data zeroed, valid still strobed
        m_axi_rvalid = 1'b1; m_axi_rresp = 2'b10; m_axi_rdata = pat_b; m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        check("t5_rsp_valid", rsp_valid, 1'b1);
        check("t5_rsp_data0", rsp_data, '0);
        check("t5_err_resp", err_resp, 1'b1);

        areset = 1'b1;
        tick();
        areset = 1'b0;
        tick();
        check("t5_rst_outst", {outstanding, err_resp}, {4'd0, 1'b0});

        // Unexpected beat with nothing outstanding
        m_axi_rvalid = 1'b1; m_axi_rdata = pat_a; m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        check("t5_unexp_err", err_resp, 1'b1);
        check("t5_unexp_outst", outstanding, 4'd0);
        check("t5_unexp_valid", {rsp_valid, rsp_last}, {1'b1, 1'b1});

        // RID mismatch in the same cycle as status_clr: set wins
        status_clr = 1'b1; m_axi_rvalid = 1'b1; m_axi_rid = 4'h3; m_axi_rdata = pat_b;
        tick();
        status_clr = 1'b0; m_axi_rvalid = 1'b0; m_axi_rid = 4'h0;
        check("t5_set_wins", err_resp, 1'b1);
        check("t5_rid_data0", rsp_data, '0);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        check("t5_clr", err_resp, 1'b0);

        // Timeout after 16 idle cycles with one read outstanding
        m_axi_arready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0000_3000;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        m_axi_arready = 1'b0;
        check("t6_outst", outstanding, 4'd1);
        repeat (15) tick();
        check("t6_not_yet", err_timeout, 1'b0);
        tick();
        check("t6_timeout", err_timeout, 1'b1);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        check("t6_persist", err_timeout, 1'b1);

        // Asynchronous reset mid-wait, then a late beat
        areset = 1'b1;
        #2;
        check("t6_async_ar", {m_axi_arvalid, m_axi_araddr}, {1'b0, 32'h0});
        check("t6_async_flags", {err_drop, err_resp, err_timeout, drop_cnt, outstanding}, '0);
        check("t6_async_r", {m_axi_rready, rsp_valid, rsp_last}, 3'b000);
        tick();
        areset = 1'b0;
        tick();
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        check("t6_late_err", err_resp, 1'b1);
        check("t6_late_outst", outstanding, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
